// File: rtl/pixel_row_readout.sv
// Row sequencer: erase, expose, ramp conversion and read for one pixel row, then streams the
// captured pixel codes over a valid/ready handshake. All outputs are registered.
module pixel_row_readout #(
  parameter int unsigned PIXEL_ARRAY_WIDTH = 2,
  parameter int unsigned PIXEL_BITS        = 8,
  parameter int unsigned ERASE_CYCLES      = 5,
  parameter int unsigned EXPOSE_CYCLES     = 255,
  localparam int unsigned IdxW = (PIXEL_ARRAY_WIDTH > 1) ? $clog2(PIXEL_ARRAY_WIDTH) : 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  output logic                                  erase,
  output logic                                  expose,
  output logic                                  analog_ramp,
  output logic [7:0]                            digital_ramp,
  output logic                                  read,
  input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0] row_data,
  output logic                                  pixel_valid,
  input  logic                                  pixel_ready,
  output logic [PIXEL_BITS-1:0]                 pixel_data,
  output logic [IdxW-1:0]                       pixel_index,
  output logic                                  busy,
  output logic                                  frame_done
);

  localparam int unsigned MaxPhase = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
  localparam int unsigned MaxCnt   = (MaxPhase > 2) ? MaxPhase : 2;
  localparam int unsigned CntW     = $clog2(MaxCnt + 1);

  typedef enum logic [2:0] {
    StIdle, StErase, StExpose, StConvert, StRead, StStream, StDone
  } state_e;

  state_e                state;
  logic [CntW-1:0]       cnt;
  logic [PIXEL_BITS-1:0] row_buf [PIXEL_ARRAY_WIDTH];
  logic [IdxW-1:0]       idx_next;

  assign idx_next = pixel_index + 1'b1;

  // Capture buffer is intentionally never cleared; it is only visible during streaming.
  always_ff @(posedge clk) begin
    if (state == StRead && cnt == CntW'(2)) begin
      for (int i = 0; i < PIXEL_ARRAY_WIDTH; i++) begin
        row_buf[i] <= row_data[i*PIXEL_BITS +: PIXEL_BITS];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= StIdle;
      cnt          <= '0;
      erase        <= 1'b0;
      expose       <= 1'b0;
      analog_ramp  <= 1'b0;
      digital_ramp <= '0;
      read         <= 1'b0;
      pixel_valid  <= 1'b0;
      pixel_data   <= '0;
      pixel_index  <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (start) begin
            state <= StErase;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        // cnt tracks how many cycles the phase output has already been high.
        StErase: begin
          if (cnt == CntW'(ERASE_CYCLES)) begin
            erase  <= 1'b0;
            expose <= 1'b1;
            cnt    <= CntW'(1);
            state  <= StExpose;
          end else begin
            erase <= 1'b1;
            cnt   <= cnt + 1'b1;
          end
        end
        StExpose: begin
          if (cnt == CntW'(EXPOSE_CYCLES)) begin
            expose       <= 1'b0;
            analog_ramp  <= 1'b1;
            digital_ramp <= '0;
            state        <= StConvert;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StConvert: begin
          if (digital_ramp == 8'hFF) begin
            analog_ramp  <= 1'b0;
            digital_ramp <= '0;
            read         <= 1'b1;
            cnt          <= CntW'(1);
            state        <= StRead;
          end else begin
            digital_ramp <= digital_ramp + 1'b1;
          end
        end
        StRead: begin
          if (cnt == CntW'(2)) begin
            read        <= 1'b0;
            pixel_valid <= 1'b1;
            pixel_index <= '0;
            pixel_data  <= row_data[PIXEL_BITS-1:0];
            state       <= StStream;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StStream: begin
          if (pixel_ready) begin
            if (pixel_index == IdxW'(PIXEL_ARRAY_WIDTH - 1)) begin
              pixel_valid <= 1'b0;
              pixel_data  <= '0;
              pixel_index <= '0;
              frame_done  <= 1'b1;
              state       <= StDone;
            end else begin
              pixel_index <= idx_next;
              pixel_data  <= row_buf[idx_next];
            end
          end
        end
        StDone: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_row_readout.sv
// Bench for pixel_row_readout: default instance plus a 4-wide, 1/1-cycle instance, both checked
// cycle by cycle against a schedule computed from the frame timeline and a pixel scoreboard.
module tb_pixel_row_readout;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic ready = 1'b0;
  logic sel = 1'b0;
  logic [15:0] row_a;
  logic [31:0] row_b;
  logic [7:0] codes [4];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic erase_a, expose_a, analog_a, read_a, valid_a, busy_a, done_a;
  logic [7:0] ramp_a, data_a;
  logic [0:0] idx_a;
  logic erase_b, expose_b, analog_b, read_b, valid_b, busy_b, done_b;
  logic [7:0] ramp_b, data_b;
  logic [1:0] idx_b;

  pixel_row_readout u_a (
    .clk(clk), .reset(reset), .start(start & ~sel), .erase(erase_a), .expose(expose_a),
    .analog_ramp(analog_a), .digital_ramp(ramp_a), .read(read_a), .row_data(row_a),
    .pixel_valid(valid_a), .pixel_ready(ready), .pixel_data(data_a), .pixel_index(idx_a),
    .busy(busy_a), .frame_done(done_a)
  );

  pixel_row_readout #(
    .PIXEL_ARRAY_WIDTH(4), .PIXEL_BITS(8), .ERASE_CYCLES(1), .EXPOSE_CYCLES(1)
  ) u_b (
    .clk(clk), .reset(reset), .start(start & sel), .erase(erase_b), .expose(expose_b),
    .analog_ramp(analog_b), .digital_ramp(ramp_b), .read(read_b), .row_data(row_b),
    .pixel_valid(valid_b), .pixel_ready(ready), .pixel_data(data_b), .pixel_index(idx_b),
    .busy(busy_b), .frame_done(done_b)
  );

  wire logic [11:0] ctrl_a = {erase_a, expose_a, analog_a, ramp_a, read_a};
  wire logic [11:0] ctrl_b = {erase_b, expose_b, analog_b, ramp_b, read_b};
  wire logic [12:0] strm_a = {valid_a, 1'b0, idx_a, data_a, done_a, busy_a};
  wire logic [12:0] strm_b = {valid_b, idx_b, data_b, done_b, busy_b};
  wire logic [11:0] ctrl   = sel ? ctrl_b : ctrl_a;
  wire logic [12:0] strm   = sel ? strm_b : strm_a;

  task automatic check(input string tag, input int t, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, got, exp);
    end
  endtask

  // Control outputs expected t cycles after the edge that accepted START.
  function automatic logic [11:0] exp_ctrl(input int t, input int e, input int x);
    logic er = 1'b0, ex = 1'b0, an = 1'b0, rd = 1'b0;
    logic [7:0] rp = 8'h00;
    if (t >= 1 && t <= e) er = 1'b1;
    else if (t > e && t <= e + x) ex = 1'b1;
    else if (t > e + x && t <= e + x + 256) begin
      an = 1'b1;
      rp = 8'(t - e - x - 1);
    end else if (t > e + x + 256 && t <= e + x + 258) rd = 1'b1;
    return {er, ex, an, rp, rd};
  endfunction

  // mode: 0 ready always high, 1 stall 7 cycles at index 0, 2 random ready.
  task automatic run_frame(input int e, input int x, input int w, input int mode,
                           input bit poke);
    int k = 0, stall = 0, tl = -1;
    bit finished = 1'b0;
    bit rdy;
    logic [12:0] es;
    start = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (tl >= 0 && t == tl + 1) es = 13'b0_00_00000000_1_1;
      else if (tl >= 0) es = '0;
      else if (t >= e + x + 259) es = {1'b1, 2'(k), codes[k], 1'b0, 1'b1};
      else es = 13'b0_00_00000000_0_1;
      check("ctrl", t, 32'(ctrl), 32'(exp_ctrl(t, e, x)));
      check("stream", t, 32'(strm), 32'(es));
      if (tl >= 0 && t == tl + 2) begin
        finished = 1'b1;
        break;
      end
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = (stall >= 7);
      else rdy = 1'($urandom_range(0, 1));
      if (poke && (t == e + 3 || (tl >= 0 && t == tl + 1))) start = 1'b1;
      if (tl < 0 && t >= e + x + 259) begin
        stall++;
        if (rdy) begin
          k++;
          if (k == w) tl = t;
        end
      end
      ready = rdy;
    end
    check("frame_complete", 0, 32'(finished), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_a", i, 32'({ctrl_a, strm_a}), 32'd0);
      check("idle_b", i, 32'({ctrl_b, strm_b}), 32'd0);
    end
  endtask

  initial begin
    row_a = 16'hA53C;
    row_b = '0;
    codes[0] = 8'h3C; codes[1] = 8'hA5; codes[2] = 8'h00; codes[3] = 8'h00;
    #1;
    check("reset_a", 0, 32'({ctrl_a, strm_a}), 32'd0);
    check("reset_b", 0, 32'({ctrl_b, strm_b}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(20);

    sel = 1'b0;
    run_frame(5, 255, 2, 0, 1'b0);
    run_frame(5, 255, 2, 1, 1'b0);
    run_frame(5, 255, 2, 0, 1'b1);
    idle_cycles(10);

    // Abort mid-conversion, then a fresh frame must run with full phase lengths.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5 + 255 + 1 + 128) @(negedge clk);
    check("ramp_mid", 0, 32'({analog_a, ramp_a}), 32'h180);
    #1 reset = 1'b1;
    #1 check("async_reset", 0, 32'({ctrl_a, strm_a}), 32'd0);
    #1 reset = 1'b0;
    run_frame(5, 255, 2, 0, 1'b0);

    sel = 1'b1;
    for (int f = 0; f < 3; f++) begin
      row_b = $urandom;
      for (int i = 0; i < 4; i++) codes[i] = row_b[i*8 +: 8];
      run_frame(1, 1, 4, 2, 1'b0);
    end
    idle_cycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pixel_row_readout.md
# pixel_row_readout

Sequencer and readout controller for one PIXEL_ROW. On a start request it drives the row through erase, exposure and ramp conversion by generating ERASE, EXPOSE, ANALOG_RAMP, READ and the 8-bit DIGITAL_RAMP count. It then captures the row's packed DATA_OUT bus and streams the pixel codes out one at a time over a valid/ready handshake. It sits between the row instance and the frame-level buffer or output logic.

## Interface
- PIXEL_ARRAY_WIDTH, 2: pixels per row; must match the driven row.
- PIXEL_BITS, 8: bits per pixel code.
- ERASE_CYCLES, 5: cycles ERASE is held high; minimum 1.
- EXPOSE_CYCLES, 255: cycles EXPOSE is held high; minimum 1.
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-high reset.
- START  input  1  frame request; sampled only in IDLE.
- ERASE  output  1  to row ERASE.
- EXPOSE  output  1  to row EXPOSE.
- ANALOG_RAMP  output  1  to row ANALOG_RAMP; high during CONVERT.
- DIGITAL_RAMP  output  8  to row DIGITAL_RAMP.
- READ  output  1  to row READ.
- ROW_DATA  input  PIXEL_ARRAY_WIDTH*PIXEL_BITS  from row DATA_OUT; pixel i is in bits [i*PIXEL_BITS +: PIXEL_BITS].
- PIXEL_VALID  output  1  stream valid.
- PIXEL_READY  input  1  stream ready from the consumer.
- PIXEL_DATA  output  PIXEL_BITS  current pixel code.
- PIXEL_INDEX  output  clog2(PIXEL_ARRAY_WIDTH), min 1  column of the current pixel.
- BUSY  output  1  high in every state except IDLE.
- FRAME_DONE  output  1  one-cycle pulse after the last pixel is accepted.

## Operation
- States: IDLE, ERASE, EXPOSE, CONVERT, READ, STREAM, DONE.
- IDLE: all outputs are 0. START=1 moves to ERASE.
- ERASE: ERASE=1 for exactly ERASE_CYCLES cycles, then EXPOSE.
- EXPOSE: EXPOSE=1 for exactly EXPOSE_CYCLES cycles, then CONVERT.
- CONVERT: ANALOG_RAMP=1 and DIGITAL_RAMP=0,1,…,255, one step per cycle, for 256 cycles. After the cycle with value 255, go to READ. The 8-bit counter wraps to 0 and DIGITAL_RAMP returns to 0 outside CONVERT.
- READ: READ=1 for 2 cycles. ROW_DATA is registered into the capture buffer on the clock edge that ends the second cycle. Then STREAM with index 0.
- STREAM:
  - PIXEL_VALID=1 and PIXEL_DATA = buffer[PIXEL_INDEX].
  - A transfer happens on a cycle with PIXEL_VALID & PIXEL_READY; the index then increments.
  - While PIXEL_VALID & !PIXEL_READY, PIXEL_DATA and PIXEL_INDEX are held stable.
  - The transfer at index PIXEL_ARRAY_WIDTH-1 moves to DONE. PIXEL_VALID drops the next cycle.
- DONE: FRAME_DONE=1 for one cycle, then IDLE.
- START outside IDLE is ignored. No queuing.
- Only the current state's control output is high. ERASE, EXPOSE, ANALOG_RAMP and READ are never high together.
- All outputs are registered (Moore), with no combinational path from START or PIXEL_READY to any output.
- The capture buffer is not cleared between frames. It is not observable outside STREAM.

## Timing
- Reset: asserting RESET clears all outputs asynchronously: state IDLE, counters 0, DIGITAL_RAMP=0, PIXEL_INDEX=0, PIXEL_VALID=0, FRAME_DONE=0. This applies mid-operation, e.g. mid-CONVERT or with a pending stream beat. The first START is accepted on the first rising edge after RESET deasserts.
- Let edge 0 be the edge where START=1 is sampled in IDLE. Then:
  - ERASE is high after edges 1..ERASE_CYCLES.
  - EXPOSE follows for EXPOSE_CYCLES cycles.
  - CONVERT follows for 256 cycles.
  - READ follows for 2 cycles.
  - The first PIXEL_VALID is at cycle 1+ERASE_CYCLES+EXPOSE_CYCLES+258. With the defaults that is cycle 519.
- With PIXEL_READY tied high, one pixel transfers per cycle. FRAME_DONE pulses the cycle after the last transfer. BUSY falls on the same cycle FRAME_DONE falls.
- START high on the FRAME_DONE cycle is ignored. START high on the first IDLE cycle begins a new frame.

## Test plan
- Reset defaults: RESET=1, then release. Outputs are all 0 and BUSY=0. START=0 for 20 cycles keeps all outputs at 0.
- Full frame, defaults, PIXEL_READY=1, row model returns codes 0x3C (col 0) and 0xA5 (col 1):
  - ERASE high for 5 cycles, EXPOSE for 255, DIGITAL_RAMP steps 0..255, READ for 2.
  - Stream beats (0,0x3C) then (1,0xA5).
  - FRAME_DONE pulses once.
- Backpressure: hold PIXEL_READY=0 for 7 cycles at index 0. PIXEL_DATA=0x3C and PIXEL_INDEX=0 stay stable throughout. The pixel transfers exactly once when PIXEL_READY rises.
- Ignored START: pulse START during EXPOSE and again on the FRAME_DONE cycle. Only one frame runs and phase lengths are unchanged.
- Reset mid-CONVERT at DIGITAL_RAMP=0x80: ANALOG_RAMP=0 and DIGITAL_RAMP=0 immediately, with no clock edge needed. A new START restarts from ERASE with full phase lengths.
- Parameter sweep PIXEL_ARRAY_WIDTH=4, ERASE_CYCLES=1, EXPOSE_CYCLES=1, random PIXEL_READY:
  - Indices 0..3 in order with the matching codes.
  - First PIXEL_VALID at cycle 261.
